ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device command transmitter, the counterpart of the existing mouse receive path. It sends one command byte to the PS/2 mouse, for example 0xF4 to enable data reporting or 0xFF to reset. It drives the open-drain PS2_CLK/PS2_DAT lines through output enables and checks the device's line ACK. The top level arbitrates the lines and holds the mouse receiver off while busy=1.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles the host holds PS2_CLK low before the request (120 us at 50 MHz)
TIMEOUT_CYCLES, 750000, maximum clk cycles from request start to line ACK (15 ms)

Ports:
clk  input  1  system clock, CLOCK_50 domain
reset  input  1  asynchronous, active-high reset
cmd_data  input  8  command byte to send
cmd_valid  input  1  request; accepted in a cycle where cmd_valid && cmd_ready
cmd_ready  output  1  high only in IDLE
ps2_clk_in  input  1  raw PS2_CLK line level (asynchronous)
ps2_dat_in  input  1  raw PS2_DAT line level (asynchronous)
ps2_clk_oe  output  1  1 = pull PS2_CLK low; top level ties PS2_CLK = oe ? 0 : 'z
ps2_dat_oe  output  1  1 = pull PS2_DAT low
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of transaction
err_code  output  2  valid when done=1: 0 ok, 1 timeout, 2 no line ACK, 3 bad response
resp_byte  output  8  device response byte (optional feature)
resp_valid  output  1  one-cycle pulse with resp_byte (optional feature)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1. State IDLE; lines released. Reset mid-transaction releases both lines immediately (asynchronously), with no done pulse.
- Input sync: ps2_clk_in and ps2_dat_in pass through 2-flop synchronizers. A falling edge (fe) is sync_clk previous 1, current 0.
- Frame on accept: frame = {stop=1, parity=~^cmd_data, cmd_data[7:0]}, shifted out LSB first. The parity bit makes the 9-bit count of ones odd.
- IDLE: cmd_ready=1. On accept, latch the frame and go to INHIBIT. A cmd_valid that arrives while busy is ignored; cmd_ready=0.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. In the last cycle, dat_oe=1 (start bit) and the state moves to REQ.
- REQ: dat_oe=1, clk_oe=0 from the first REQ cycle. Wait for fe.
- SEND: On each fe, set dat_oe = ~frame[bit_idx] and increment bit_idx (4 bits, 0..9).
  - Edges 1-8 carry data bits, edge 9 the parity bit, edge 10 the stop bit (dat_oe=0).
  - After edge 10, go to WAIT_ACK.
- WAIT_ACK: On the next fe, sample sync_dat. Value 0 means ACK: go to WAIT_IDLE. Value 1 ends the transaction with err_code=2.
- WAIT_IDLE: wait until sync_clk=1 and sync_dat=1, then finish with err_code 0. With the optional feature enabled, go to RX instead.
- Timeout: a counter is cleared on accept and runs INHIBIT through WAIT_IDLE. When it reaches TIMEOUT_CYCLES, release both lines and finish with err_code=1. If an fe and the timeout occur in the same cycle, the timeout wins.
- Finish: done=1 for one cycle together with err_code; next cycle IDLE, cmd_ready=1. Both oe outputs are 0 in the done cycle.
- Latency with an ideal device: INHIBIT_CYCLES + 1 + 11 device clock periods + idle detect + 1 cycle to done.

Optional Feature:
Macro PS2_TX_RESP_EN.
- Enabled: WAIT_IDLE moves to RX.
  - RX receives one 11-bit device frame, sampling sync_dat on each fe: start 0, 8 data bits LSB first, odd parity, stop 1.
  - A fresh TIMEOUT_CYCLES window starts on entry to RX.
  - On the stop bit: resp_byte = data and resp_valid pulses in the same cycle as done.
  - err_code=3 if start≠0, stop≠1, parity wrong, or data≠8'hFA; resp_byte holds the received value anyway.
- Disabled: resp_byte=0 and resp_valid=0 permanently; the ports remain so the top level needs no change.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, SEND, WAIT_ACK, WAIT_IDLE, RX, FINISH}
  - constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RESP_ACK=8'hFA
  - err_code constants ERR_NONE/ERR_TIMEOUT/ERR_NOACK/ERR_RESP
- Sub-module ps2_line_sync: 2-flop synchronizers for both lines plus the clk falling-edge strobe. It is reusable by the mouse receive path.

Test Plan:
Run all scenarios with INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=4000, against a bench device model with a 60-clk PS/2 period.
1. Send 0xF4; device ACKs. Check clk_oe high for exactly 20 cycles and start bit 0. Sampled bits must be 0,0,1,0,1,1,1,1, parity 0, stop 1. Expect done with err_code=0 and cmd_ready back to 1.
2. Send 0xFF. Expect parity bit 1 and err_code=0; with PS2_TX_RESP_EN and the device answering 0xFA, expect resp_valid=1 and resp_byte=8'hFA.
3. Device never clocks. Expect both oe=0 and done with err_code=1 exactly 4000 cycles after accept.
4. Device leaves DAT high in the ACK slot. Expect err_code=2 and both lines released.
5. Assert reset after the 4th data bit. Expect ps2_clk_oe=ps2_dat_oe=0 in the same cycle, no done pulse, and cmd_ready=1 after release. Then a new 0xF4 completes with err_code=0.
6. Hold cmd_valid with 0x00 while busy during scenario 1. Expect cmd_ready=0, no second accept, and exactly one done pulse. PS2_TX_RESP_EN with a device reply of 0xFE: expect err_code=3 and resp_byte=8'hFE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command path.
// Response checking in ps2_host_tx is built only when PS2_TX_RESP_EN is defined.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    RX,
    FINISH
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NOACK   = 2'd2;
  localparam logic [1:0] ERR_RESP    = 2'd3;

  localparam int unsigned TX_FRAME_W = 10;
  localparam int unsigned RX_FRAME_W = 11;
  localparam int unsigned BIT_IDX_W  = 4;

  // {stop, odd parity, data}; shifted out LSB first after the start bit
  function automatic logic [TX_FRAME_W-1:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

  // Device frame {stop, parity, data, start} carrying a good ACK byte
  function automatic logic ps2_rx_ok(input logic [RX_FRAME_W-1:0] frame);
    return (frame[0] == 1'b0) && frame[10] && (^frame[9:1]) &&
           (frame[8:1] == PS2_RESP_ACK);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a falling-edge strobe
// on the synchronized clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_sync_clk,
  output logic o_sync_dat,
  output logic o_clk_fe_c
);

  logic [1:0] r_clk_s;
  logic [1:0] r_dat_s;
  logic       r_clk_q;

  // Reset to the idle-high bus level so release never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_q <= 1'b1;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_dat};
      r_clk_q <= r_clk_s[1];
    end
  end

  assign o_sync_clk = r_clk_s[1];
  assign o_sync_dat = r_dat_s[1];
  assign o_clk_fe_c = r_clk_q & ~r_clk_s[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with line-ACK check and timeout.
// Define PS2_TX_RESP_EN to also receive and check the device response byte.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  output logic [7:0] resp_byte,
  output logic       resp_valid
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] TX_LAST   = BIT_IDX_W'(TX_FRAME_W - 1);

  ps2_state_e r_state;
  ps2_state_e w_state_nxt;
  logic [1:0] w_err_nxt;

  logic [CNT_W-1:0]      r_cnt;
  logic [TX_FRAME_W-1:0] r_frame;
  logic [BIT_IDX_W-1:0]  r_bit_idx;
  logic                  r_dat_drv;
  logic [1:0]            r_err;

  logic w_sync_clk;
  logic w_sync_dat;
  logic w_clk_fe;
  logic w_tmo;
  logic w_active;
  logic w_rx_start;

`ifdef PS2_TX_RESP_EN
  localparam logic [BIT_IDX_W-1:0] RX_LAST = BIT_IDX_W'(RX_FRAME_W - 1);
  logic [RX_FRAME_W-2:0] r_rx;
  logic [7:0]            r_resp_byte;
  logic                  r_resp_got;
  logic [RX_FRAME_W-1:0] w_rx_frame;
  assign w_rx_frame = {w_sync_dat, r_rx};
`endif

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_dat  (ps2_dat_in),
    .o_sync_clk (w_sync_clk),
    .o_sync_dat (w_sync_dat),
    .o_clk_fe_c (w_clk_fe)
  );

  assign w_tmo      = (r_cnt == TMO_LAST);
  assign w_active   = (r_state != IDLE) && (r_state != FINISH);
  assign w_rx_start = (r_state == WAIT_IDLE) && (w_state_nxt == RX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; timeout overrides any edge seen in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = ERR_NONE;
    case (r_state)
      IDLE:      if (cmd_valid) w_state_nxt = INHIBIT;
      INHIBIT:   if (r_cnt == INH_LAST) w_state_nxt = REQ;
      REQ, SEND: if (w_clk_fe) w_state_nxt = (r_bit_idx == TX_LAST) ? WAIT_ACK : SEND;
      WAIT_ACK: begin
        if (w_clk_fe) begin
          if (!w_sync_dat) begin
            w_state_nxt = WAIT_IDLE;
          end else begin
            w_state_nxt = FINISH;
            w_err_nxt   = ERR_NOACK;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_sync_clk && w_sync_dat) begin
`ifdef PS2_TX_RESP_EN
          w_state_nxt = RX;
`else
          w_state_nxt = FINISH;
`endif
        end
      end
      RX: begin
`ifdef PS2_TX_RESP_EN
        if (w_clk_fe && (r_bit_idx == RX_LAST)) begin
          w_state_nxt = FINISH;
          w_err_nxt   = ps2_rx_ok(w_rx_frame) ? ERR_NONE : ERR_RESP;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (w_active && w_tmo) begin
      w_state_nxt = FINISH;
      w_err_nxt   = ERR_TIMEOUT;
    end
  end

  // Outputs decoded from registered state, so reset releases the lines at once
  always_comb begin
    cmd_ready  = (r_state == IDLE);
    busy       = (r_state != IDLE);
    done       = (r_state == FINISH);
    err_code   = (r_state == FINISH) ? r_err : ERR_NONE;
    ps2_clk_oe = (r_state == INHIBIT);
    ps2_dat_oe = 1'b0;
    case (r_state)
      INHIBIT: ps2_dat_oe = (r_cnt == INH_LAST);
      REQ:     ps2_dat_oe = 1'b1;
      SEND:    ps2_dat_oe = r_dat_drv;
      default: ps2_dat_oe = 1'b0;
    endcase
`ifdef PS2_TX_RESP_EN
    resp_byte  = r_resp_byte;
    resp_valid = (r_state == FINISH) && r_resp_got;
`else
    resp_byte  = 8'h00;
    resp_valid = 1'b0;
`endif
  end

  // Timeout/inhibit counter, transmit shifter and latched error code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_frame   <= '0;
      r_bit_idx <= '0;
      r_dat_drv <= 1'b0;
      r_err     <= ERR_NONE;
    end else begin
      if (r_state == IDLE || w_rx_start) r_cnt <= '0;
      else                               r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == IDLE) begin
        r_bit_idx <= '0;
        r_dat_drv <= 1'b0;
        if (cmd_valid) r_frame <= ps2_tx_frame(cmd_data);
      end else if (w_rx_start) begin
        r_bit_idx <= '0;
      end else if (w_clk_fe && (r_state == REQ || r_state == SEND)) begin
        r_dat_drv <= ~r_frame[0];
        r_frame   <= {1'b0, r_frame[TX_FRAME_W-1:1]};
        r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
      end else if (w_clk_fe && r_state == RX) begin
        r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
      end

      if (w_state_nxt == FINISH && r_state != FINISH) r_err <= w_err_nxt;
    end
  end

`ifdef PS2_TX_RESP_EN
  // Device response shifter; the byte is kept even when it is not an ACK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx        <= '0;
      r_resp_byte <= 8'h00;
      r_resp_got  <= 1'b0;
    end else begin
      if (r_state == IDLE) r_resp_got <= 1'b0;
      if (r_state == RX && w_clk_fe) r_rx <= {w_sync_dat, r_rx[RX_FRAME_W-2:1]};
      if (r_state == RX && w_state_nxt == FINISH && w_err_nxt != ERR_TIMEOUT) begin
        r_resp_byte <= w_rx_frame[8:1];
        r_resp_got  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx against an open-drain PS/2 device model
// with a 60-clk bus period; response checks follow PS2_TX_RESP_EN.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic [7:0] resp_byte;
  logic       resp_valid;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .resp_byte  (resp_byte),
    .resp_valid (resp_valid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Negedge monitor: pulse counts, inhibit length and done-cycle snapshot
  int         cyc = 0, done_cnt = 0, acc_cnt = 0;
  int         clk_run = 0, last_clk_run = 0, busy_cyc = 0, done_cyc = 0;
  logic       busy_q = 1'b0;
  logic [1:0] done_err = 2'd0;
  logic [1:0] done_oe = 2'd0;
  logic       done_rv = 1'b0;
  logic [7:0] done_rb = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready && !reset) acc_cnt++;
    if (busy && !busy_q) busy_cyc = cyc;
    busy_q = busy;
    if (ps2_clk_oe) clk_run++;
    else if (clk_run != 0) begin
      last_clk_run = clk_run;
      clk_run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err_code;
      done_oe  = {ps2_clk_oe, ps2_dat_oe};
      done_rv  = resp_valid;
      done_rb  = resp_byte;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic keep_valid);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      tick(1);
      k++;
    end
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick(1);
    if (keep_valid) cmd_data = 8'h00;
    else            cmd_valid = 1'b0;
  endtask

  // Device side of a host request: clocks npulses bits, then the ACK slot
  task automatic dev_tx(input int npulses, input logic ack,
                        output logic [9:0] bits, output logic start_line);
    int k = 0;
    bits = '0;
    start_line = 1'b1;
    while (!(ps2_dat_oe && !ps2_clk_oe) && k < 200) begin
      tick(1);
      k++;
    end
    check("req_seen", 32'(k < 200), 32'd1);
    start_line = ps2_dat_in;
    tick(10);
    for (int i = 0; i < npulses; i++) begin
      dev_clk_low = 1'b1;
      tick(30);
      bits[i] = ps2_dat_in;
      dev_clk_low = 1'b0;
      tick(30);
    end
    if (npulses == 10) begin
      dev_dat_low = ack;
      tick(5);
      dev_clk_low = 1'b1;
      tick(30);
      dev_clk_low = 1'b0;
      tick(2);
      dev_dat_low = 1'b0;
    end
  endtask

`ifdef PS2_TX_RESP_EN
  task automatic dev_resp(input logic [7:0] d);
    logic [10:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    tick(20);
    for (int i = 0; i < 11; i++) begin
      dev_dat_low = ~f[i];
      tick(5);
      dev_clk_low = 1'b1;
      tick(30);
      dev_clk_low = 1'b0;
      tick(25);
    end
    dev_dat_low = 1'b0;
  endtask
`endif

  task automatic wait_done(input int d0, input int bound);
    int k = 0;
    while (done_cnt == d0 && k < bound) begin
      tick(1);
      k++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic       start_line;
    int         d0, a0;

    reset = 1'b1;
    cmd_data = 8'h00;
    cmd_valid = 1'b0;
    tick(3);

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_byte}), 32'd0);
    reset = 1'b0;
    tick(3);

    // Enable command with ACK, cmd_valid held at 0x00 while busy
    d0 = done_cnt;
    a0 = acc_cnt;
    send_cmd(PS2_CMD_ENABLE, 1'b1);
    check("s1_ready_busy", 32'(cmd_ready), 32'd0);
    dev_tx(10, 1'b1, bits, start_line);
    cmd_valid = 1'b0;
`ifdef PS2_TX_RESP_EN
    dev_resp(PS2_RESP_ACK);
`endif
    wait_done(d0, 300);
    check("s1_inhibit_len", 32'(last_clk_run), 32'(INH));
    check("s1_start_bit", 32'(start_line), 32'd0);
    check("s1_frame_bits", 32'(bits), 32'h2F4);
    check("s1_err", 32'(done_err), 32'(ERR_NONE));
    check("s1_ready_after", 32'(cmd_ready), 32'd1);
    tick(5);
    check("s1_one_done", 32'(done_cnt - d0), 32'd1);
    check("s1_one_accept", 32'(acc_cnt - a0), 32'd1);

    // Reset command: parity bit 1
    d0 = done_cnt;
    send_cmd(PS2_CMD_RESET, 1'b0);
    dev_tx(10, 1'b1, bits, start_line);
`ifdef PS2_TX_RESP_EN
    dev_resp(PS2_RESP_ACK);
`endif
    wait_done(d0, 300);
    check("s2_frame_bits", 32'(bits), 32'h3FF);
    check("s2_err", 32'(done_err), 32'(ERR_NONE));
`ifdef PS2_TX_RESP_EN
    check("s2_resp", 32'({done_rv, done_rb}), 32'h1FA);
`else
    check("s2_resp", 32'({done_rv, done_rb}), 32'h000);
`endif
    tick(5);

    // Silent device: timeout exactly TMO cycles after accept
    d0 = done_cnt;
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    wait_done(d0, TMO + 100);
    check("s3_err", 32'(done_err), 32'(ERR_TIMEOUT));
    check("s3_oe_done", 32'(done_oe), 32'd0);
    check("s3_latency", 32'(done_cyc - busy_cyc), 32'(TMO));
    tick(5);

    // No line ACK
    d0 = done_cnt;
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    dev_tx(10, 1'b0, bits, start_line);
    wait_done(d0, 300);
    check("s4_err", 32'(done_err), 32'(ERR_NOACK));
    check("s4_oe_done", 32'(done_oe), 32'd0);
    check("s4_oe_after", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    tick(5);

    // Reset after the 4th data bit
    d0 = done_cnt;
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    dev_tx(4, 1'b1, bits, start_line);
    check("s5_bits_lo", 32'(bits[3:0]), 32'h4);
    check("s5_dat_oe_pre", 32'(ps2_dat_oe), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("s5_oe_async", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(3);
    check("s5_no_done", 32'(done_cnt - d0), 32'd0);
    check("s5_ready", 32'(cmd_ready), 32'd1);
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    dev_tx(10, 1'b1, bits, start_line);
`ifdef PS2_TX_RESP_EN
    dev_resp(PS2_RESP_ACK);
`endif
    wait_done(d0, 300);
    check("s5_frame_bits", 32'(bits), 32'h2F4);
    check("s5_err", 32'(done_err), 32'(ERR_NONE));
    tick(5);

`ifdef PS2_TX_RESP_EN
    // Device answers with a resend request instead of ACK
    d0 = done_cnt;
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    dev_tx(10, 1'b1, bits, start_line);
    dev_resp(8'hFE);
    wait_done(d0, 300);
    check("s6_err", 32'(done_err), 32'(ERR_RESP));
    check("s6_resp", 32'({done_rv, done_rb}), 32'h1FE);
    tick(5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
